exp_add_sched: RTL and testbench

//  Schedules one shared 13-bit exponent adder (exp_add) among NREQ FPU requesters, e.g. FMA, div/sqrt, cvt.

---
 rtl/exp_add_sched_if.sv | 28 ++
 rtl/exp_add_sched.sv | 152 +++++++++++++++
 tb/tb_exp_add_sched.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_add_sched_if.sv
// Request/response bundle between FPU exponent units and the shared exponent adder.
interface exp_add_sched_if #(
   parameter int NREQ = 3,
   parameter int TAGW = 4
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*13-1:0]   req_a;
   logic [NREQ*13-1:0]   req_b;
   logic [NREQ-1:0]      req_cin;
   logic [NREQ*TAGW-1:0] req_tag;
   logic [NREQ-1:0]      req_lock;
   logic [NREQ-1:0]      rsp_valid;
   logic [NREQ-1:0]      rsp_ready;
   logic [12:0]          rsp_sum;
   logic                 rsp_cout;
   logic [TAGW-1:0]      rsp_tag;

   modport master (
      output req_valid, req_a, req_b, req_cin, req_tag, req_lock, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, req_tag, req_lock, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_tag
   );
endinterface

// File: rtl/exp_add_sched.sv
// Round-robin scheduler for one shared 13-bit exponent adder, two-stage pipeline.
// Optional EXPADD_LOCK_EN lets a requester hold the adder across several ops.
module exp_add (
   input  logic [12:0] a,
   input  logic [12:0] b,
   input  logic        cin,
   output logic [12:0] sum,
   output logic        cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {13'b0, cin};
endmodule

module exp_add_sched #(
   parameter int NREQ = 3,
   parameter int TAGW = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic flush,
   output logic busy,
   exp_add_sched_if.slave bus
);
   localparam int IW = $clog2(NREQ);

   logic [IW-1:0]   ptr;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_found;
   logic [NREQ-1:0] elig;
   logic            accept;
   logic            s1_adv;
   logic            s2_adv;

   logic            s1_v;
   logic [IW-1:0]   s1_own;
   logic [12:0]     s1_a;
   logic [12:0]     s1_b;
   logic            s1_cin;
   logic [TAGW-1:0] s1_tag;

   logic            s2_v;
   logic [IW-1:0]   s2_own;
   logic [12:0]     s2_sum;
   logic            s2_cout;
   logic [TAGW-1:0] s2_tag;

   logic [12:0]     add_sum;
   logic            add_cout;

`ifdef EXPADD_LOCK_EN
   logic            lock_v;
   logic [IW-1:0]   lock_own;

   always_comb begin
      elig = bus.req_valid;
      if (lock_v) elig = bus.req_valid & (NREQ'(1) << lock_own);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_v   <= 1'b0;
         lock_own <= '0;
      end else if (flush) begin
         lock_v   <= 1'b0;
      end else if (accept) begin
         lock_v   <= bus.req_lock[gnt_idx];
         lock_own <= gnt_idx;
      end
   end
`else
   logic unused_lock;
   assign unused_lock = ^bus.req_lock;
   assign elig = bus.req_valid;
`endif

   // first eligible requester after the last granted one, wrapping
   always_comb begin
      int j;
      j         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!gnt_found && elig[IW'(j)]) begin
            gnt_found = 1'b1;
            gnt_idx   = IW'(j);
         end
      end
   end

   assign s2_adv = !s2_v || bus.rsp_ready[s2_own];
   assign s1_adv = !s1_v || s2_adv;
   assign accept = gnt_found && s1_adv && !flush;

   assign bus.req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;
   assign bus.rsp_valid = s2_v ? (NREQ'(1) << s2_own) : '0;
   assign bus.rsp_sum   = s2_sum;
   assign bus.rsp_cout  = s2_cout;
   assign bus.rsp_tag   = s2_tag;
   assign busy          = s1_v || s2_v;

   exp_add u_exp_add (
      .a    (s1_a),
      .b    (s1_b),
      .cin  (s1_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr     <= IW'(NREQ - 1);
         s1_v    <= 1'b0;
         s1_own  <= '0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_cin  <= 1'b0;
         s1_tag  <= '0;
         s2_v    <= 1'b0;
         s2_own  <= '0;
         s2_sum  <= '0;
         s2_cout <= 1'b0;
         s2_tag  <= '0;
      end else begin
         if (accept) ptr <= gnt_idx;
         if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
         end else begin
            if (s2_adv) begin
               s2_v <= s1_v;
               if (s1_v) begin
                  s2_own  <= s1_own;
                  s2_sum  <= add_sum;
                  s2_cout <= add_cout;
                  s2_tag  <= s1_tag;
               end
            end
            if (s1_adv) begin
               s1_v <= accept;
               if (accept) begin
                  s1_own <= gnt_idx;
                  s1_a   <= bus.req_a[13*gnt_idx +: 13];
                  s1_b   <= bus.req_b[13*gnt_idx +: 13];
                  s1_cin <= bus.req_cin[gnt_idx];
                  s1_tag <= bus.req_tag[TAGW*gnt_idx +: TAGW];
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_exp_add_sched.sv
// Directed bench for exp_add_sched with a response scoreboard.
// Lock scenario compiles only when EXPADD_LOCK_EN is defined.
module tb_exp_add_sched;
   localparam int NREQ = 3;
   localparam int TAGW = 4;

   typedef struct packed {
      logic [1:0]      own;
      logic [12:0]     sum;
      logic            cout;
      logic [TAGW-1:0] tag;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic busy;

   logic [NREQ-1:0] vld   = '0;
   logic [NREQ-1:0] lck   = '0;
   logic [NREQ-1:0] rrdy  = '1;
   logic [NREQ-1:0] cin_r = '0;
   logic [12:0]     a_r   [NREQ];
   logic [12:0]     b_r   [NREQ];
   logic [TAGW-1:0] tag_r [NREQ];

   exp_t q [$];
   int   gq [$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   exp_add_sched_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

   exp_add_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .busy  (busy),
      .bus   (bus.slave)
   );

   assign bus.req_valid = vld;
   assign bus.req_lock  = lck;
   assign bus.req_cin   = cin_r;
   assign bus.rsp_ready = rrdy;

   always_comb begin
      bus.req_a   = '0;
      bus.req_b   = '0;
      bus.req_tag = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[13*i +: 13]     = a_r[i];
         bus.req_b[13*i +: 13]     = b_r[i];
         bus.req_tag[TAGW*i +: TAGW] = tag_r[i];
      end
   end

   task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
      end
   endtask

   function automatic exp_t model(input int i);
      logic [13:0] r;
      exp_t e;
      r      = {1'b0, a_r[i]} + {1'b0, b_r[i]} + {13'b0, cin_r[i]};
      e.own  = 2'(i);
      e.sum  = r[12:0];
      e.cout = r[13];
      e.tag  = tag_r[i];
      return e;
   endfunction

   // scoreboard: push on accept, pop on response handshake
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
      end else begin
         if (bus.rsp_valid != '0 && q.size() == 0)
            chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
         else if ((bus.rsp_valid & rrdy) != '0) begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_owner", 32'(bus.rsp_valid), 32'(3'b001 << e.own));
            chk("rsp_sum",   32'(bus.rsp_sum),   32'(e.sum));
            chk("rsp_cout",  32'(bus.rsp_cout),  32'(e.cout));
            chk("rsp_tag",   32'(bus.rsp_tag),   32'(e.tag));
         end
         if (flush) q.delete();
         for (int i = 0; i < NREQ; i++)
            if (vld[i] && bus.req_ready[i]) begin
               q.push_back(model(i));
               gq.push_back(i);
            end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic [12:0] a, input logic [12:0] b,
                        input logic c, input logic [TAGW-1:0] t, input logic l);
      a_r[i]   = a;
      b_r[i]   = b;
      cin_r[i] = c;
      tag_r[i] = t;
      lck[i]   = l;
      vld[i]   = 1'b1;
   endtask

   task automatic wait_acc(input int i);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready[i] && n < 30) begin
         n++;
         @(negedge clk);
      end
      if (!bus.req_ready[i]) chk("accept_timeout", 32'h0, 32'h1);
      step();
      vld[i] = 1'b0;
      lck[i] = 1'b0;
   endtask

   task automatic send(input int i, input logic [12:0] a, input logic [12:0] b,
                       input logic c, input logic [TAGW-1:0] t);
      drive(i, a, b, c, t, 1'b0);
      wait_acc(i);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || q.size() != 0) && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_queue", 32'(q.size()), 32'h0);
      step();
   endtask

   task automatic chk_grants(input string nm, input int exp_g [$]);
      chk({nm, "_count"}, 32'(gq.size()), 32'(exp_g.size()));
      if (gq.size() == exp_g.size())
         for (int k = 0; k < exp_g.size(); k++)
            chk(nm, 32'(gq[k]), 32'(exp_g[k]));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         a_r[i]   = '0;
         b_r[i]   = '0;
         tag_r[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_busy",      32'(busy),          32'h0);
      chk("rst_rsp_sum",   32'(bus.rsp_sum),   32'h0);
      chk("rst_rsp_cout",  32'(bus.rsp_cout),  32'h0);
      chk("rst_rsp_tag",   32'(bus.rsp_tag),   32'h0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      reset = 1'b0;
      step();

      // T1: latency and basic sum
      drive(0, 13'h03FF, 13'h0001, 1'b0, 4'd3, 1'b0);
      @(negedge clk);
      chk("t1_ready", 32'(bus.req_ready), 32'h1);
      step();
      vld[0] = 1'b0;
      chk("t1_busy", 32'(busy), 32'h1);
      chk("t1_no_rsp_yet", 32'(bus.rsp_valid), 32'h0);
      step();
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("t1_sum",  32'(bus.rsp_sum),  32'h0400);
      chk("t1_cout", 32'(bus.rsp_cout), 32'h0);
      chk("t1_tag",  32'(bus.rsp_tag),  32'h3);
      step();
      chk("t1_drained", 32'(bus.rsp_valid), 32'h0);
      wait_idle();

      // T2: carry out of bit 12, via b and via cin
      send(1, 13'h1FFF, 13'h0001, 1'b0, 4'd5);
      send(1, 13'h1FFF, 13'h0000, 1'b1, 4'd6);
      wait_idle();

      // reset with an op in flight drops it
      rrdy = '0;
      send(2, 13'h0100, 13'h0100, 1'b0, 4'd9);
      step();
      chk("mid_rst_pre", 32'(bus.rsp_valid), 32'h4);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
      step();
      step();
      reset = 1'b0;
      rrdy  = '1;
      repeat (3) step();
      chk("mid_rst_after", 32'(bus.rsp_valid), 32'h0);
      chk("mid_rst_busy",  32'(busy), 32'h0);

      // T3: round robin from reset, one result per cycle
      gq.delete();
      drive(0, 13'h0011, 13'h0022, 1'b0, 4'd1, 1'b0);
      drive(1, 13'h0F00, 13'h0100, 1'b1, 4'd2, 1'b0);
      drive(2, 13'h1800, 13'h0800, 1'b1, 4'd4, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k >= 2) chk("t3_rsp_each_cycle", 32'(bus.rsp_valid != '0), 32'h1);
      end
      vld = '0;
      wait_idle();
      chk_grants("t3_grant", '{0, 1, 2, 0, 1, 2});

      // T4: backpressure on the owner only; other ready bits are ignored
      rrdy = '0;
      send(0, 13'h0AAA, 13'h0555, 1'b1, 4'd1);
      send(0, 13'h1000, 13'h1000, 1'b0, 4'd2);
      rrdy = 3'b110;
      drive(1, 13'h0010, 13'h0020, 1'b0, 4'd4, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t4_req_ready", 32'(bus.req_ready), 32'h0);
         chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'h1);
         chk("t4_rsp_sum",   32'(bus.rsp_sum),   32'h1000);
         chk("t4_rsp_tag",   32'(bus.rsp_tag),   32'h1);
      end
      step();
      rrdy = '1;
      wait_acc(1);
      wait_idle();

      // T5: flush wins over a pending request and kills S1/S2
      rrdy = '0;
      send(0, 13'h0001, 13'h0002, 1'b0, 4'd7);
      send(0, 13'h0003, 13'h0004, 1'b0, 4'd8);
      drive(0, 13'h0005, 13'h0006, 1'b1, 4'd9, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      chk("t5_flush_ready", 32'(bus.req_ready), 32'h0);
      step();
      flush = 1'b0;
      chk("t5_busy", 32'(busy), 32'h0);
      chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      rrdy = '1;
      wait_acc(0);
      wait_idle();

`ifdef EXPADD_LOCK_EN
      // T6: req2 locks the adder for three ops while req0 waits
      gq.delete();
      drive(0, 13'h0001, 13'h0001, 1'b0, 4'd10, 1'b0);
      drive(2, 13'h0002, 13'h0003, 1'b0, 4'd11, 1'b1);
      wait_acc(2);
      drive(2, 13'h0004, 13'h0005, 1'b0, 4'd12, 1'b1);
      wait_acc(2);
      drive(2, 13'h0006, 13'h0007, 1'b0, 4'd13, 1'b0);
      wait_acc(2);
      wait_acc(0);
      wait_idle();
      chk_grants("t6_grant", '{2, 2, 2, 0});
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
